// File: rtl/rr_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_req_arbiter_pkg
// Brief    : Shared widths, FSM state type and payload layout for the
//            round-robin request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_req_arbiter_pkg;

    localparam int DEF_ID_WIDTH   = 3;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int TOTAL_WIDTH    = DEF_ID_WIDTH + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

    // IDLE arbitrates, GRANT forwards the granted source
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Payload as seen by the downstream FIFO, MSB to LSB
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } payload_t;

endpackage
`default_nettype wire

// File: rtl/rr_req_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first valid index starting at
//            ptr and wrapping modulo NUM_SRC.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // Scan in reverse priority order so the highest-priority hit is written last
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = |valid;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (valid[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_req_arbiter
// Brief    : Merges NUM_SRC valid/ready sources into one {id, addr, data}
//            stream with round-robin grants held for bursts of up to
//            MAX_BURST beats.
// Revision : 1.0 - initial release
// ============================================================================
module rr_req_arbiter
    import rr_req_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NUM_SRC-1:0]                    src_valid,
    output logic [NUM_SRC-1:0]                    src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]         src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]         src_data,
    output logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] out_payload,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ID_WIDTH-1:0]                   grant_id
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t         r_st, w_st_nxt;
    logic [IDX_W-1:0]   r_cur, w_cur_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any_valid;
    logic [NUM_SRC-1:0] w_cur_onehot;
    logic               w_cur_valid;
    logic               w_others_valid;
    logic               w_handshake;
    logic               w_last_beat;
    logic               w_release;
    logic               w_active;

    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_SRC];

    // Unpack the flat source buses so the payload mux can index by r_cur
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_addr_arr[g] = src_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid     (src_valid),
        .ptr       (r_ptr),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    // Grant qualifiers: handshake, last burst beat and release conditions
    always_comb begin
        w_cur_onehot   = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_cur;
        w_cur_valid    = src_valid[r_cur];
        w_others_valid = |(src_valid & ~w_cur_onehot);
        w_handshake    = (r_st == ST_GRANT) && w_cur_valid && out_ready;
        w_last_beat    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
        w_release      = (r_st == ST_GRANT) &&
                         ((w_handshake && w_last_beat) || (!w_cur_valid && w_others_valid));
    end

    // Next-state: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        w_st_nxt  = r_st;
        w_cur_nxt = r_cur;
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_beat_cnt;
        case (r_st)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_st_nxt  = ST_GRANT;
                    w_cur_nxt = w_winner;
                    w_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_st_nxt  = ST_IDLE;
                    w_ptr_nxt = (r_cur == IDX_W'(NUM_SRC - 1)) ? '0 : r_cur + IDX_W'(1);
                    w_cnt_nxt = '0;
                end else if (w_handshake) begin
                    w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_st_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_st       <= ST_IDLE;
            r_cur      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_st       <= w_st_nxt;
            r_cur      <= w_cur_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Datapath mux, gated off in IDLE and while reset is asserted
    always_comb begin
        w_active    = rstn && (r_st == ST_GRANT);
        out_valid   = w_active && w_cur_valid;
        src_ready   = (w_active && out_ready) ? w_cur_onehot : '0;
        out_payload = w_active ? {ID_WIDTH'(r_cur), w_addr_arr[r_cur], w_data_arr[r_cur]} : '0;
        grant_id    = (r_st == ST_GRANT) ? ID_WIDTH'(r_cur) : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_req_arbiter
// Brief    : Self-checking bench for rr_req_arbiter: directed scenarios plus
//            randomized traffic against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_req_arbiter;
    import rr_req_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N*AW-1:0]   src_addr;
    logic [N*DW-1:0]   src_data;
    logic [IW+AW+DW-1:0] out_payload;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     grant_id;

    int checks   = 0;
    int failures = 0;

    // Reference model: whether a grant is held, its owner, the search start
    // and the number of beats already accepted in this grant
    bit m_busy  = 1'b0;
    int m_cur   = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    int hs_count = 0;
    int hs_ids[$];

    always #5 clk = ~clk;

    rr_req_arbiter #(
        .NUM_SRC    (N),
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .out_payload (out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_id    (grant_id)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the model at the falling edge
    task automatic model_check();
        payload_t     p;
        logic [N-1:0] er;
        bit           act;
        @(negedge clk);
        act    = (rstn === 1'b1) && m_busy;
        p.id   = IW'(m_cur);
        p.addr = src_addr[m_cur*AW +: AW];
        p.data = src_data[m_cur*DW +: DW];
        er     = (act && out_ready) ? N'(1 << m_cur) : '0;
        check("out_valid", 128'(out_valid), 128'(act && src_valid[m_cur]));
        check("src_ready", 128'(src_ready), 128'(er));
        check("out_payload", 128'(out_payload), act ? 128'(p) : 128'(0));
        check("grant_id", 128'(grant_id), m_busy ? 128'(m_cur) : 128'(0));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_count++;
            hs_ids.push_back(int'(grant_id));
        end
    endtask

    // Apply the arbitration rules to the inputs of this cycle, then step time
    task automatic model_advance();
        bit n_busy;
        int n_cur, n_ptr, n_beats, idx;
        bit others;
        n_busy = m_busy; n_cur = m_cur; n_ptr = m_ptr; n_beats = m_beats;
        if (rstn !== 1'b1) begin
            n_busy = 0; n_cur = 0; n_ptr = 0; n_beats = 0;
        end else if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (m_ptr + k) % N;
                if (src_valid[idx]) begin
                    n_busy = 1; n_cur = idx; n_beats = 0;
                end
            end
        end else begin
            others = 0;
            for (int j = 0; j < N; j++) if (j != m_cur && src_valid[j]) others = 1;
            if ((src_valid[m_cur] && out_ready && m_beats == MB - 1) ||
                (!src_valid[m_cur] && others)) begin
                n_busy = 0; n_ptr = (m_cur + 1) % N; n_beats = 0;
            end else if (src_valid[m_cur] && out_ready) begin
                n_beats = m_beats + 1;
            end
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_cur = n_cur; m_ptr = n_ptr; m_beats = n_beats;
    endtask

    task automatic do_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            model_check();
            model_advance();
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        do_cycles(1);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        src_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_addr[i*AW +: AW] = 32'h1000 + 32'(i);
            src_data[i*DW +: DW] = 32'hD0 + 32'(i);
        end

        // Reset state
        do_cycles(2);
        rstn = 1'b1;
        model_check();
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_grant", 128'(grant_id), 128'(0));
        model_advance();

        // Single source with one cycle arbitration latency
        src_valid = 4'b0010;
        src_addr[1*AW +: AW] = 32'h100;
        src_data[1*DW +: DW] = 32'hA;
        out_ready = 1'b1;
        do_cycles(1);
        model_check();
        check("single_valid", 128'(out_valid), 128'(1));
        check("single_payload", 128'(out_payload), 128'({3'd1, 32'h100, 32'hA}));
        check("single_ready", 128'(src_ready), 128'(4'b0010));
        check("single_grant", 128'(grant_id), 128'(1));
        model_advance();
        src_valid = '0;
        do_cycles(2);

        // All sources continuously valid: 16 beats over 20 cycles
        pulse_reset();
        src_valid = 4'b1111;
        do_cycles(1);
        hs_count = 0;
        hs_ids.delete();
        do_cycles(20);
        check("rr_beats", 128'(hs_count), 128'(16));
        for (int i = 0; i < 16 && i < hs_ids.size(); i++) begin
            check("rr_order", 128'(hs_ids[i]), 128'(i / 4));
        end
        model_check();
        check("rr_wrap_grant", 128'(grant_id), 128'(0));
        model_advance();

        // Backpressure during beat 2 of src0
        pulse_reset();
        src_valid = 4'b0001;
        hs_count  = 0;
        do_cycles(2);
        out_ready = 1'b0;
        do_cycles(2);
        model_check();
        check("stall_ready", 128'(src_ready), 128'(0));
        check("stall_valid", 128'(out_valid), 128'(1));
        model_advance();
        out_ready = 1'b1;
        do_cycles(3);
        check("stall_burst", 128'(hs_count), 128'(4));
        src_valid = '0;
        do_cycles(1);

        // Early release from src2 to src3
        pulse_reset();
        src_valid = 4'b1100;
        do_cycles(3);
        src_valid = 4'b1000;
        do_cycles(2);
        model_check();
        check("early_grant", 128'(grant_id), 128'(3));
        model_advance();

        // Only src0 valid for 10 beats: 4+4+2 with bubbles
        pulse_reset();
        src_valid = 4'b0001;
        hs_count  = 0;
        hs_ids.delete();
        do_cycles(13);
        src_valid = '0;
        check("solo_beats", 128'(hs_count), 128'(10));
        for (int i = 0; i < hs_ids.size(); i++) begin
            check("solo_id", 128'(hs_ids[i]), 128'(0));
        end
        do_cycles(1);

        // Reset in the middle of a src1 burst
        pulse_reset();
        src_valid = 4'b0010;
        do_cycles(2);
        rstn      = 1'b0;
        src_valid = 4'b0011;
        do_cycles(1);
        rstn = 1'b1;
        model_check();
        check("rst_bubble", 128'(out_valid), 128'(0));
        model_advance();
        model_check();
        check("rst_regrant", 128'(grant_id), 128'(0));
        model_advance();

        // Randomized traffic, backpressure and occasional resets
        for (int c = 0; c < 800; c++) begin
            src_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rstn      = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) begin
                    src_addr[i*AW +: AW] = $urandom;
                    src_data[i*DW +: DW] = $urandom;
                end
            end
            do_cycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
